// File: rtl/simple_exe_wb_pkg.sv
// Shared execute-stage definitions: flag bit positions and the writeback entry layout.
package simple_exe_wb_pkg;

    localparam int FLAG_MISPRED = 0;
    localparam int FLAG_EXC     = 1;
    localparam int FLAG_EXEC    = 2;
    localparam int FLAG_DEST    = 4;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_TAG_W   = 7;
    localparam int DEF_ALID_W  = 7;
    localparam int DEF_FLAGS_W = 6;

    typedef struct packed {
        logic [DEF_DATA_W-1:0]  data;
        logic [DEF_TAG_W-1:0]   tag;
        logic [DEF_ALID_W-1:0]  alid;
        logic [DEF_FLAGS_W-1:0] flags;
    } wb_entry_t;

endpackage

// File: rtl/simple_exe_wb_if.sv
// ALU-result, bypass and writeback signal bundle; the stage itself uses the slave view.
interface simple_exe_wb_if #(
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 7,
    parameter int ALID_W  = 7,
    parameter int FLAGS_W = 6
);
    logic               valid_i;
    logic [DATA_W-1:0]  result_i;
    logic [FLAGS_W-1:0] flags_i;
    logic [TAG_W-1:0]   tag_i;
    logic [ALID_W-1:0]  alid_i;
    logic               ready_o;
    logic               flush_i;
    logic               byp_valid_o;
    logic [TAG_W-1:0]   byp_tag_o;
    logic [DATA_W-1:0]  byp_data_o;
    logic               wb_valid_o;
    logic               wb_ready_i;
    logic [DATA_W-1:0]  wb_data_o;
    logic [TAG_W-1:0]   wb_tag_o;
    logic [ALID_W-1:0]  wb_alid_o;
    logic [FLAGS_W-1:0] wb_flags_o;

    modport slave (
        input  valid_i, result_i, flags_i, tag_i, alid_i, flush_i, wb_ready_i,
        output ready_o, byp_valid_o, byp_tag_o, byp_data_o,
               wb_valid_o, wb_data_o, wb_tag_o, wb_alid_o, wb_flags_o
    );

    modport master (
        output valid_i, result_i, flags_i, tag_i, alid_i, flush_i, wb_ready_i,
        input  ready_o, byp_valid_o, byp_tag_o, byp_data_o,
               wb_valid_o, wb_data_o, wb_tag_o, wb_alid_o, wb_flags_o
    );

endinterface

// File: rtl/exe_wb_fifo.sv
// Synchronous FIFO with flush, occupancy count and a registered head entry.
module exe_wb_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_din,
    output logic [CNT_W-1:0] o_count,
    output logic [WIDTH-1:0] o_head
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_head;

    logic [PW-1:0]    w_wr_nxt;
    logic [PW-1:0]    w_rd_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] w_head_nxt;

    // The head register is loaded with whatever entry will sit at the read pointer after this edge.
    always_comb begin
        w_rd_nxt   = r_rd_ptr + PW'(i_pop);
        w_wr_nxt   = r_wr_ptr + PW'(i_push);
        w_cnt_nxt  = r_count + CNT_W'(i_push) - CNT_W'(i_pop);
        w_head_nxt = r_mem[w_rd_nxt];
        if (i_push && (r_wr_ptr == w_rd_nxt)) begin
            w_head_nxt = i_din;
        end
        if (w_cnt_nxt == '0) begin
            w_head_nxt = '0;
        end
        if (i_flush) begin
            w_rd_nxt   = '0;
            w_wr_nxt   = '0;
            w_cnt_nxt  = '0;
            w_head_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else begin
            r_wr_ptr <= w_wr_nxt;
            r_rd_ptr <= w_rd_nxt;
            r_count  <= w_cnt_nxt;
            r_head   <= w_head_nxt;
        end
    end

    assign o_count = r_count;
    assign o_head  = r_head;

endmodule

// File: rtl/simple_exe_wb.sv
// ALU output stage: one-shot bypass broadcast plus a writeback FIFO toward the active list.
// Optional pop/exception counters are built when SIMPLE_EXE_WB_PERF_CNT_EN is defined.
module simple_exe_wb
    import simple_exe_wb_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TAG_W   = DEF_TAG_W,
    parameter int ALID_W  = DEF_ALID_W,
    parameter int FLAGS_W = DEF_FLAGS_W,
    parameter int DEPTH   = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    simple_exe_wb_if.slave    bus
`ifdef SIMPLE_EXE_WB_PERF_CNT_EN
    ,
    output logic [31:0]       perf_done_o,
    output logic [31:0]       perf_exc_o
`endif
);
    localparam int ENTRY_W = DATA_W + TAG_W + ALID_W + FLAGS_W;
    localparam int CNT_W   = $clog2(DEPTH + 1);

    logic [CNT_W-1:0]   w_count;
    logic [ENTRY_W-1:0] w_din;
    logic [ENTRY_W-1:0] w_head;
    logic               w_ready;
    logic               w_wb_valid;
    logic               w_accept;
    logic               w_pop;

    logic               r_byp_valid;
    logic [TAG_W-1:0]   r_byp_tag;
    logic [DATA_W-1:0]  r_byp_data;

    // No pass-through: a full FIFO refuses input even on a cycle it pops.
    assign w_ready    = (w_count != CNT_W'(DEPTH));
    assign w_wb_valid = (w_count != '0);
    assign w_accept   = bus.valid_i && w_ready && !bus.flush_i;
    assign w_pop      = w_wb_valid && bus.wb_ready_i;
    assign w_din      = {bus.result_i, bus.tag_i, bus.alid_i, bus.flags_i};

    exe_wb_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_accept),
        .i_pop   (w_pop),
        .i_flush (bus.flush_i),
        .i_din   (w_din),
        .o_count (w_count),
        .o_head  (w_head)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_byp_valid <= 1'b0;
            r_byp_tag   <= '0;
            r_byp_data  <= '0;
        end else begin
            r_byp_valid <= w_accept && bus.flags_i[FLAG_DEST];
            if (w_accept) begin
                r_byp_tag  <= bus.tag_i;
                r_byp_data <= bus.result_i;
            end
        end
    end

`ifdef SIMPLE_EXE_WB_PERF_CNT_EN
    logic [31:0] r_perf_done;
    logic [31:0] r_perf_exc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_perf_done <= '0;
            r_perf_exc  <= '0;
        end else if (w_pop) begin
            r_perf_done <= r_perf_done + 32'd1;
            r_perf_exc  <= r_perf_exc + 32'(w_head[FLAG_EXC]);
        end
    end

    assign perf_done_o = r_perf_done;
    assign perf_exc_o  = r_perf_exc;
`endif

    assign bus.ready_o     = w_ready;
    assign bus.wb_valid_o  = w_wb_valid;
    assign bus.byp_valid_o = r_byp_valid;
    assign bus.byp_tag_o   = r_byp_tag;
    assign bus.byp_data_o  = r_byp_data;
    assign {bus.wb_data_o, bus.wb_tag_o, bus.wb_alid_o, bus.wb_flags_o} = w_head;

endmodule

// File: tb/tb_simple_exe_wb.sv
// Randomised scoreboard bench for simple_exe_wb: driver pushes expected entries, monitor pops and compares.
module tb_simple_exe_wb;
    import simple_exe_wb_pkg::*;

    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    simple_exe_wb_if #(
        .DATA_W (DEF_DATA_W),
        .TAG_W  (DEF_TAG_W),
        .ALID_W (DEF_ALID_W),
        .FLAGS_W(DEF_FLAGS_W)
    ) bus ();

`ifdef SIMPLE_EXE_WB_PERF_CNT_EN
    logic [31:0] perf_done;
    logic [31:0] perf_exc;
`endif

    simple_exe_wb #(
        .DATA_W (DEF_DATA_W),
        .TAG_W  (DEF_TAG_W),
        .ALID_W (DEF_ALID_W),
        .FLAGS_W(DEF_FLAGS_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
`ifdef SIMPLE_EXE_WB_PERF_CNT_EN
        ,
        .perf_done_o (perf_done),
        .perf_exc_o  (perf_exc)
`endif
    );

    wb_entry_t   sb_q[$];
    wb_entry_t   mon_act;
    int          n_chk  = 0;
    int          n_pass = 0;
    bit          mon_en = 1'b0;
    bit          cyc_ready = 1'b1;
    bit          exp_bv = 1'b0;
    logic [6:0]  exp_bt = '0;
    logic [31:0] exp_bd = '0;
    int unsigned m_done = 0;
    int unsigned m_exc  = 0;
    logic [6:0]  alid_ctr = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: compares what the DUT presents this cycle against the model, retiring on handshake.
    always @(posedge clk) begin
        #2;
        if (mon_en) begin
            chk("ready_o", 64'(bus.ready_o), 64'(sb_q.size() != DEPTH));
            cyc_ready = (sb_q.size() != DEPTH);
            chk("wb_valid_o", 64'(bus.wb_valid_o), 64'(sb_q.size() != 0));
            if (bus.wb_valid_o && sb_q.size() != 0) begin
                mon_act = {bus.wb_data_o, bus.wb_tag_o, bus.wb_alid_o, bus.wb_flags_o};
                chk("wb_head", 64'(mon_act), 64'(sb_q[0]));
            end
            chk("byp_valid_o", 64'(bus.byp_valid_o), 64'(exp_bv));
            if (exp_bv && bus.byp_valid_o) begin
                chk("byp_tag_o", 64'(bus.byp_tag_o), 64'(exp_bt));
                chk("byp_data_o", 64'(bus.byp_data_o), 64'(exp_bd));
            end
`ifdef SIMPLE_EXE_WB_PERF_CNT_EN
            chk("perf_done_o", 64'(perf_done), 64'(m_done));
            chk("perf_exc_o", 64'(perf_exc), 64'(m_exc));
`endif
            if (bus.wb_valid_o && bus.wb_ready_i && sb_q.size() != 0) begin
                m_done++;
                if (sb_q[0].flags[FLAG_EXC]) m_exc++;
                void'(sb_q.pop_front());
            end
        end
    end

    // Driver: one clock of stimulus, then records what the stage is expected to take in.
    task automatic cycle(input bit v, input logic [31:0] d, input logic [5:0] f,
                         input logic [6:0] t, input bit fl, input bit wr);
        wb_entry_t e;
        @(posedge clk);
        #1;
        alid_ctr      = alid_ctr + 7'd1;
        bus.valid_i   = v;
        bus.result_i  = d;
        bus.flags_i   = f;
        bus.tag_i     = t;
        bus.alid_i    = alid_ctr;
        bus.flush_i   = fl;
        bus.wb_ready_i = wr;
        #2;
        if (fl) begin
            sb_q.delete();
            exp_bv = 1'b0;
        end else if (v && cyc_ready) begin
            e.data = d; e.tag = t; e.alid = alid_ctr; e.flags = f;
            sb_q.push_back(e);
            exp_bv = f[FLAG_DEST];
            exp_bt = t;
            exp_bd = d;
        end else begin
            exp_bv = 1'b0;
        end
    endtask

    task automatic idle(input int n, input bit wr);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'd0, 6'd0, 7'd0, 1'b0, wr);
    endtask

    task automatic check_reset_outputs(input string pfx);
        chk({pfx, "_ready_o"},     64'(bus.ready_o), 64'd1);
        chk({pfx, "_wb_valid_o"},  64'(bus.wb_valid_o), 64'd0);
        chk({pfx, "_byp_valid_o"}, 64'(bus.byp_valid_o), 64'd0);
        chk({pfx, "_byp_tag_o"},   64'(bus.byp_tag_o), 64'd0);
        chk({pfx, "_byp_data_o"},  64'(bus.byp_data_o), 64'd0);
        chk({pfx, "_wb_head"},     64'({bus.wb_data_o, bus.wb_tag_o, bus.wb_alid_o, bus.wb_flags_o}), 64'd0);
`ifdef SIMPLE_EXE_WB_PERF_CNT_EN
        chk({pfx, "_perf_done_o"}, 64'(perf_done), 64'd0);
        chk({pfx, "_perf_exc_o"},  64'(perf_exc), 64'd0);
`endif
    endtask

    task automatic clear_model();
        sb_q.delete();
        exp_bv = 1'b0;
        m_done = 0;
        m_exc  = 0;
        cyc_ready = 1'b1;
    endtask

    task automatic async_reset_mid_cycle();
        @(posedge clk);
        #4;
        reset_n = 1'b0;
        mon_en  = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        clear_model();
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        mon_en  = 1'b1;
    endtask

    initial begin
        reset_n        = 1'b0;
        bus.valid_i    = 1'b0;
        bus.result_i   = '0;
        bus.flags_i    = '0;
        bus.tag_i      = '0;
        bus.alid_i     = '0;
        bus.flush_i    = 1'b0;
        bus.wb_ready_i = 1'b0;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;
        mon_en  = 1'b1;

        // Single op with destination write, consumer ready.
        cycle(1'b1, 32'h0000_0005, 6'h14, 7'd12, 1'b0, 1'b1);
        idle(2, 1'b1);

        // Back-pressure: third op refused while full, then drained in order.
        cycle(1'b1, 32'h1111_0001, 6'h14, 7'd20, 1'b0, 1'b0);
        cycle(1'b1, 32'h2222_0002, 6'h14, 7'd21, 1'b0, 1'b0);
        cycle(1'b1, 32'h3333_0003, 6'h14, 7'd22, 1'b0, 1'b0);
        idle(4, 1'b1);

        // NOP: queued for completion but never bypassed.
        cycle(1'b1, 32'hABCD_0000, 6'h04, 7'd30, 1'b0, 1'b1);
        idle(2, 1'b1);

        // Flush with two entries queued and a valid op on the flush cycle.
        cycle(1'b1, 32'h4444_0004, 6'h14, 7'd40, 1'b0, 1'b0);
        cycle(1'b1, 32'h5555_0005, 6'h14, 7'd41, 1'b0, 1'b0);
        cycle(1'b1, 32'hDEAD_BEEF, 6'h14, 7'd42, 1'b1, 1'b0);
        idle(2, 1'b1);

        // Simultaneous push and pop at count 1.
        cycle(1'b1, 32'h6666_0006, 6'h10, 7'd50, 1'b0, 1'b0);
        cycle(1'b1, 32'h7777_0007, 6'h12, 7'd51, 1'b0, 1'b1);
        idle(1, 1'b0);
        idle(2, 1'b1);

        // Asynchronous reset while entries are draining.
        cycle(1'b1, 32'h8888_0008, 6'h14, 7'd60, 1'b0, 1'b0);
        cycle(1'b1, 32'h9999_0009, 6'h16, 7'd61, 1'b0, 1'b0);
        cycle(1'b0, 32'd0, 6'd0, 7'd0, 1'b0, 1'b1);
        async_reset_mid_cycle();

        // Three pops, one carrying the exception bit.
        cycle(1'b1, 32'h0000_00A1, 6'h14, 7'd70, 1'b0, 1'b1);
        cycle(1'b1, 32'h0000_00A2, 6'h16, 7'd71, 1'b0, 1'b1);
        cycle(1'b1, 32'h0000_00A3, 6'h04, 7'd72, 1'b0, 1'b1);
        idle(2, 1'b1);
`ifdef SIMPLE_EXE_WB_PERF_CNT_EN
        chk("perf_done_after3", 64'(perf_done), 64'd3);
        chk("perf_exc_after3", 64'(perf_exc), 64'd1);
`endif

        // Randomised traffic with occasional flushes and consumer stalls.
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom % 10) < 7, $urandom, 6'($urandom), 7'($urandom),
                  ($urandom % 24) == 0, ($urandom % 4) != 0);
        end
        idle(4, 1'b1);
        chk("drained", 64'(sb_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/simple_exe_wb.md
Name: simple_exe_wb

Overview:
- Output stage directly downstream of the simple integer ALU.
- Registers each ALU result and broadcasts it once on the bypass network.
- Queues the result, destination tag, active-list id and execution flags in a small FIFO.
- Drains the FIFO to the writeback/active-list port with a valid/ready handshake, and back-pressures issue when full.

Parameters:
- DATA_W, 32, result width (matches SIZE_DATA)
- TAG_W, 7, physical destination register tag width
- ALID_W, 7, active-list index width
- FLAGS_W, 6, execution flags width (matches EXECUTION_FLAGS)
- DEPTH, 2, writeback FIFO entries (power of two, >=2)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset_n  in  1  asynchronous active-low reset
- valid_i  in  1  ALU result valid
- result_i  in  DATA_W  ALU result
- flags_i  in  FLAGS_W  ALU flags; bit0 mispredict, bit1 exception, bit2 executed, bit4 dest-write
- tag_i  in  TAG_W  physical destination tag
- alid_i  in  ALID_W  active-list index
- ready_o  out  1  stage can accept (combinational, from occupancy only)
- flush_i  in  1  pipeline recovery
- byp_valid_o  out  1  bypass broadcast valid
- byp_tag_o  out  TAG_W  bypass tag
- byp_data_o  out  DATA_W  bypass data
- wb_valid_o  out  1  FIFO head valid
- wb_ready_i  in  1  writeback consumer ready
- wb_data_o  out  DATA_W  head result
- wb_tag_o  out  TAG_W  head tag
- wb_alid_o  out  ALID_W  head active-list index
- wb_flags_o  out  FLAGS_W  head flags

Behaviour:
- Reset (reset_n low, asynchronous): FIFO empty, pointers and count 0, every output 0 except ready_o = 1.
- Accept condition: valid_i && ready_o && !flush_i. ready_o = (count != DEPTH).
  - No same-cycle pass-through when full: ready_o stays low on a full-FIFO pop cycle.
- Bypass:
  - A result accepted in cycle N with flags_i[4] = 1 drives byp_valid_o/tag/data high for exactly cycle N+1.
  - byp_valid_o is 0 in every other cycle and does not depend on wb_ready_i.
  - flags_i[4] = 0 (e.g. NOP): no bypass, but the entry is still queued for completion.
- FIFO:
  - Push on accept; pop when wb_valid_o && wb_ready_i; both may occur in the same cycle.
  - count += push - pop.
  - Pointers wrap modulo DEPTH.
  - wb_* outputs are driven from registers (head entry). wb_valid_o = (count != 0).
  - Minimum latency from accept to wb_valid_o is 1 cycle.
  - Head fields are held stable while wb_valid_o && !wb_ready_i.
- Flags pass through unmodified, including the mispredict and exception bits. The stage does not interpret them beyond bit4.
- Flush:
  - Empties the FIFO at the next edge.
  - The input on the flush cycle is dropped.
  - Any bypass scheduled for the next cycle is suppressed.
  - wb_valid_o = 0 and ready_o = 1 from cycle N+1.
  - A pop handshake in the flush cycle still completes; flush wins for everything else.
- Ordering: strictly in acceptance order. No reordering and no entry duplication.

Optional Feature:
- Macro: SIMPLE_EXE_WB_PERF_CNT_EN.
- When defined, the block adds:
  - 32-bit outputs perf_done_o (pops completed) and perf_exc_o (pops with flags bit1 set).
  - Both are reset to 0, wrap at 2^32, and are not cleared by flush.
- When undefined, the ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- The shared execute package holds:
  - the flag bit-index constants (FLAG_MISPRED=0, FLAG_EXC=1, FLAG_EXEC=2, FLAG_DEST=4);
  - a packed struct for the writeback entry {data, tag, alid, flags}.
- One natural sub-module: exe_wb_fifo, a parameterised synchronous FIFO with flush, count and registered head outputs.
- The bypass register and perf counters stay in the top level.

Test Plan:
- Single op: ADD result 0x0000_0005, tag 12, flags 0x14, wb_ready_i = 1 -> byp_valid_o = 1 with tag 12 and data 5 in cycle N+1; wb_valid_o = 1 in N+1, popped the same cycle.
- Back-pressure: wb_ready_i = 0, three back-to-back valid_i -> first two accepted, ready_o = 0 on the third. Releasing wb_ready_i pops the entries in order and ready_o returns to 1 the cycle after the first pop.
- NOP flags 0x04 -> byp_valid_o stays 0; a writeback entry still appears with flags 0x04.
- Flush with two entries queued and valid_i = 1 -> next cycle wb_valid_o = 0, byp_valid_o = 0, ready_o = 1; the dropped op never appears.
- Simultaneous push and pop with count = 1 -> count stays 1 and the head advances to the new entry's data.
- Async reset asserted mid-drain -> all outputs 0 immediately and ready_o = 1. With SIMPLE_EXE_WB_PERF_CNT_EN, perf_done_o = 0, then 3 pops, one with flags 0x16 -> perf_done_o = 3, perf_exc_o = 1.
